// File: rtl/snn_run_ctrl.sv
// snn_run_ctrl: sequences one inference run (clear, drive spike enables, drain) and counts output spikes
module snn_run_ctrl #(
    parameter int NUM_INPUTS   = 4,
    parameter int NUM_OUTPUTS  = 1,
    parameter int STEP_WIDTH   = 16,
    parameter int CNT_WIDTH    = 16,
    parameter int CLEAR_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [STEP_WIDTH-1:0]            num_steps,
    input  logic [NUM_INPUTS-1:0]            pattern,
    input  logic [NUM_OUTPUTS-1:0]           spike_out,
    output logic [NUM_INPUTS-1:0]            spike_en,
    output logic                             net_clr,
    output logic                             busy,
    output logic                             done,
    output logic [STEP_WIDTH-1:0]            step_cnt,
    output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_cnt
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
    localparam int MAXC = CLEAR_CYCLES > DRAIN_CYCLES ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int PW = $clog2(MAXC + 1);
    state_t                  state;
    state_t                  state_nx;
    logic [PW-1:0]           phase_cnt;
    logic [NUM_INPUTS-1:0]   pat_q;
    logic [STEP_WIDTH-1:0]   steps_q;
    logic                    abort_clr;
    logic                    accept;
    logic                    kill;
    logic                    last_step;
    logic                    clr_end;
    logic                    drain_end;
    logic                    counting;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_OUTPUTS];
    assign accept    = state == IDLE && start && !abort;
    assign kill      = abort && (state == CLEAR || state == RUN || state == DRAIN);
    assign last_step = (step_cnt + STEP_WIDTH'(1)) == steps_q;
    assign clr_end   = phase_cnt == PW'(CLEAR_CYCLES - 1);
    assign drain_end = phase_cnt == PW'(DRAIN_CYCLES - 1);
    assign counting  = state == RUN || state == DRAIN;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next-state decode and outputs decoded from the registered state
    always_comb begin
        state_nx = state;
        spike_en = state == RUN ? pat_q : '0;
        net_clr  = state == CLEAR || abort_clr;
        busy     = state != IDLE;
        done     = state == DONE;
        unique case (state)
            IDLE:    state_nx = accept ? (num_steps == '0 ? DONE : CLEAR) : IDLE;
            CLEAR:   state_nx = kill ? IDLE : clr_end ? RUN : CLEAR;
            RUN:     state_nx = kill ? IDLE : last_step ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) : RUN;
            DRAIN:   state_nx = kill ? IDLE : drain_end ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // cycles spent in the current CLEAR or DRAIN phase, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst || state_nx != state) phase_cnt <= '0;
        else                          phase_cnt <= phase_cnt + PW'(1);
    end
    // run parameters are captured only when a start is accepted, so mid-run input changes are inert
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            steps_q <= '0;
        end else if (accept) begin
            pat_q   <= pattern;
            steps_q <= num_steps;
        end
    end
    // one-cycle network clear on the abort transition into IDLE
    always_ff @(posedge clk) begin
        if (rst) abort_clr <= 1'b0;
        else     abort_clr <= kill;
    end
    // RUN cycles elapsed; holds after the run until the next accepted start
    always_ff @(posedge clk) begin
        if (rst || accept)     step_cnt <= '0;
        else if (state == RUN) step_cnt <= step_cnt + STEP_WIDTH'(1);
    end
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        // saturating spike counter, live only while run-related spikes can emerge
        always_ff @(posedge clk) begin
            if (rst || accept)                               cnt_q[i] <= '0;
            else if (counting && spike_out[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
        assign spike_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
endmodule
